// File: rtl/synth_reg_write_arbiter_pkg.sv
// Shared definitions for the synth register write arbiter: address map, requester ids, freq lock states.
package synth_reg_pkg;

  localparam logic [7:0] ADDR_CTRL      = 8'h00;
  localparam logic [7:0] ADDR_FREQ_LOW  = 8'h02;
  localparam logic [7:0] ADDR_FREQ_MID  = 8'h03;
  localparam logic [7:0] ADDR_FREQ_HIGH = 8'h04;
  localparam logic [7:0] ADDR_DUTY      = 8'h05;
  localparam logic [7:0] ADDR_VOLUME    = 8'h06;
  localparam logic [7:0] ADDR_STATUS    = 8'h12;

  typedef enum logic {
    REQ_SPI  = 1'b0,
    REQ_AUTO = 1'b1
  } req_id_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOCK_SPI  = 2'd1,
    LOCK_AUTO = 2'd2
  } lock_state_t;

  function automatic logic is_freq_addr(input logic [7:0] addr);
    return (addr >= ADDR_FREQ_LOW) && (addr <= ADDR_FREQ_HIGH);
  endfunction

endpackage

// File: rtl/synth_reg_write_arbiter_if.sv
// Write handshake bundle for the two register-bank requesters (SPI and AUTO).
interface synth_reg_write_arbiter_if;
  logic       spi_valid;
  logic       spi_ready;
  logic [7:0] spi_addr;
  logic [7:0] spi_data;
  logic       auto_valid;
  logic       auto_ready;
  logic [7:0] auto_addr;
  logic [7:0] auto_data;

  modport master (
    output spi_valid, spi_addr, spi_data, auto_valid, auto_addr, auto_data,
    input  spi_ready, auto_ready
  );

  modport slave (
    input  spi_valid, spi_addr, spi_data, auto_valid, auto_addr, auto_data,
    output spi_ready, auto_ready
  );
endinterface

// File: rtl/synth_reg_write_arbiter_arb_core.sv
// Two-requester arbiter (bit 0 = SPI, bit 1 = AUTO), combinational one-hot grant.
// Default: SPI priority with starvation escape; SYNTH_REG_ARB_RR_EN selects round-robin.
module synth_reg_arb_core
  import synth_reg_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic [1:0] mask,
  output logic [1:0] grant
);

  logic [1:0] req;
  assign req = rst ? 2'b00 : (valid & ~mask);

`ifdef SYNTH_REG_ARB_RR_EN
  req_id_t last_win;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last_win == REQ_SPI) ? 2'b10 : 2'b01;
    end
  end

  // Starts as AUTO so the first contended cycle goes to SPI.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_win <= REQ_AUTO;
    end else if (req == 2'b11) begin
      last_win <= grant[1] ? REQ_AUTO : REQ_SPI;
    end
  end
`else
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (starve_cnt == CW'(STARVE_MAX)) ? 2'b10 : 2'b01;
    end
  end

  // Masked AUTO requests are not lost arbitrations, so req (not valid) drives the count.
  always_ff @(posedge clk) begin
    if (rst || grant[1]) begin
      starve_cnt <= '0;
    end else if (req[1] && (starve_cnt != CW'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/synth_reg_write_arbiter.sv
// Synth register bank: arbitrates SPI/AUTO writes, owns live regs, commits 24-bit freq atomically.
// SYNTH_REG_ARB_RR_EN switches the arbiter from SPI priority + starvation escape to round-robin.
module synth_reg_write_arbiter
  import synth_reg_pkg::*;
#(
  parameter int STARVE_MAX   = 4,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  synth_reg_write_arbiter_if.slave   wr,
  input  logic                       status_gate_active,
  input  logic                       status_osc_running,
  output logic [7:0]                 reg_control,
  output logic [7:0]                 reg_freq_low,
  output logic [7:0]                 reg_freq_mid,
  output logic [7:0]                 reg_freq_high,
  output logic [7:0]                 reg_duty,
  output logic [7:0]                 reg_volume,
  output logic [7:0]                 reg_status,
  output logic                       freq_commit,
  output logic                       addr_err
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  lock_state_t      lock_state, lock_next;
  logic [CNT_W-1:0] lock_cnt;
  logic             owner_touch;
  logic [1:0]       valid, mask, grant;
  logic             xfer;
  req_id_t          xfer_id;
  logic [7:0]       addr, data;
  logic [7:0]       shadow_low, shadow_mid;

  assign reg_status = {6'b0, status_osc_running, status_gate_active};

  assign valid = {wr.auto_valid, wr.spi_valid};

  // The non-owner is held off freq addresses while a sequence is in flight.
  always_comb begin
    mask = 2'b00;
    case (lock_state)
      LOCK_SPI:  mask[1] = is_freq_addr(wr.auto_addr);
      LOCK_AUTO: mask[0] = is_freq_addr(wr.spi_addr);
      default:   mask = 2'b00;
    endcase
  end

  synth_reg_arb_core #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .mask  (mask),
    .grant (grant)
  );

  assign wr.spi_ready  = grant[0];
  assign wr.auto_ready = grant[1];

  assign xfer    = |grant;
  assign xfer_id = grant[1] ? REQ_AUTO : REQ_SPI;
  assign addr    = grant[1] ? wr.auto_addr : wr.spi_addr;
  assign data    = grant[1] ? wr.auto_data : wr.spi_data;

  always_comb begin
    lock_next   = lock_state;
    owner_touch = 1'b0;
    case (lock_state)
      IDLE: begin
        if (xfer && ((addr == ADDR_FREQ_LOW) || (addr == ADDR_FREQ_MID))) begin
          lock_next = (xfer_id == REQ_AUTO) ? LOCK_AUTO : LOCK_SPI;
        end
      end
      LOCK_SPI, LOCK_AUTO: begin
        owner_touch = xfer && is_freq_addr(addr) &&
                      (xfer_id == ((lock_state == LOCK_AUTO) ? REQ_AUTO : REQ_SPI));
        if (owner_touch && (addr == ADDR_FREQ_HIGH)) begin
          lock_next = IDLE;
        end else if (!owner_touch && (lock_cnt == CNT_W'(LOCK_TIMEOUT - 1))) begin
          lock_next = IDLE;
        end
      end
      default: lock_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_state <= IDLE;
    end else begin
      lock_state <= lock_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (lock_state == IDLE) || owner_touch) begin
      lock_cnt <= '0;
    end else begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_control   <= 8'h00;
      reg_freq_low  <= 8'h00;
      reg_freq_mid  <= 8'h00;
      reg_freq_high <= 8'h00;
      reg_duty      <= 8'h00;
      reg_volume    <= 8'h00;
      shadow_low    <= 8'h00;
      shadow_mid    <= 8'h00;
      freq_commit   <= 1'b0;
      addr_err      <= 1'b0;
    end else begin
      freq_commit <= 1'b0;
      addr_err    <= 1'b0;
      if (xfer) begin
        case (addr)
          ADDR_CTRL:      reg_control <= data;
          ADDR_FREQ_LOW:  shadow_low  <= data;
          ADDR_FREQ_MID:  shadow_mid  <= data;
          ADDR_FREQ_HIGH: begin
            {reg_freq_high, reg_freq_mid, reg_freq_low} <= {data, shadow_mid, shadow_low};
            freq_commit <= 1'b1;
          end
          ADDR_DUTY:      reg_duty    <= data;
          ADDR_VOLUME:    reg_volume  <= data;
          ADDR_STATUS:    addr_err    <= 1'b1;
          default:        addr_err    <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_synth_reg_write_arbiter.sv
// Directed bench for synth_reg_write_arbiter: vector table plus arbitration, timeout and reset sequences.
module tb_synth_reg_write_arbiter;
  import synth_reg_pkg::*;

  localparam int STARVE_MAX   = 4;
  localparam int LOCK_TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       status_gate_active, status_osc_running;
  logic [7:0] reg_control, reg_freq_low, reg_freq_mid, reg_freq_high;
  logic [7:0] reg_duty, reg_volume, reg_status;
  logic       freq_commit, addr_err;

  int checks = 0;
  int errors = 0;

  synth_reg_write_arbiter_if bus_if ();

  synth_reg_write_arbiter #(.STARVE_MAX(STARVE_MAX), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
    .clk                (clk),
    .rst                (rst),
    .wr                 (bus_if),
    .status_gate_active (status_gate_active),
    .status_osc_running (status_osc_running),
    .reg_control        (reg_control),
    .reg_freq_low       (reg_freq_low),
    .reg_freq_mid       (reg_freq_mid),
    .reg_freq_high      (reg_freq_high),
    .reg_duty           (reg_duty),
    .reg_volume         (reg_volume),
    .reg_status         (reg_status),
    .freq_commit        (freq_commit),
    .addr_err           (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sv;
    logic [7:0] sa, sd;
    logic       av;
    logic [7:0] aa, ad;
    logic       srdy, ardy;
    logic [7:0] ctrl;
    logic [23:0] freq;
    logic [7:0] duty, vol;
    logic       commit, err;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [7:0] sa, input logic [7:0] sd,
                       input logic av, input logic [7:0] aa, input logic [7:0] ad);
    bus_if.spi_valid  = sv;
    bus_if.spi_addr   = sa;
    bus_if.spi_data   = sd;
    bus_if.auto_valid = av;
    bus_if.auto_addr  = aa;
    bus_if.auto_data  = ad;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int found;
    logic exp_auto;

    vecs[0]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 24'h000000, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h12, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 24'h000000, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 8'h02, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 24'h000000, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h03, 8'h40, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 24'h000000, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h04, 8'h02, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 24'h024000, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 24'h024000, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h00, 8'h5A, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h5A, 24'h024000, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h05, 8'h33, 1'b0, 1'b1, 8'h5A, 24'h024000, 8'h33, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 8'h77, 1'b0, 1'b1, 8'h5A, 24'h024000, 8'h33, 8'h00, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 8'h06, 8'h11, 1'b1, 8'h00, 8'h22, 1'b1, 1'b0, 8'h5A, 24'h024000, 8'h33, 8'h11, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h22, 1'b0, 1'b1, 8'h22, 24'h024000, 8'h33, 8'h11, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'h03, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h22, 24'h024000, 8'h33, 8'h11, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 8'h02, 8'hAA, 1'b1, 8'h03, 8'h11, 1'b1, 1'b0, 8'h22, 24'h024000, 8'h33, 8'h11, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 8'h06, 8'h44, 1'b1, 8'h03, 8'h11, 1'b1, 1'b0, 8'h22, 24'h024000, 8'h33, 8'h44, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 8'h04, 8'hCC, 1'b1, 8'h03, 8'h11, 1'b1, 1'b0, 8'h22, 24'hCC00AA, 8'h33, 8'h44, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h03, 8'h11, 1'b0, 1'b1, 8'h22, 24'hCC00AA, 8'h33, 8'h44, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h04, 8'h01, 1'b0, 1'b1, 8'h22, 24'h0111AA, 8'h33, 8'h44, 1'b1, 1'b0};

    status_gate_active = 1'b1;
    status_osc_running = 1'b1;

    // Readies must stay low while reset is held, even with both requesters valid.
    rst = 1'b1;
    drive(1'b1, 8'h00, 8'hFF, 1'b1, 8'h05, 8'hFF);
    @(negedge clk);
    check("rst_spi_ready", 32'(bus_if.spi_ready), 32'd0);
    check("rst_auto_ready", 32'(bus_if.auto_ready), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    check("rst_status", 32'(reg_status), 32'h03);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].sv, vecs[i].sa, vecs[i].sd, vecs[i].av, vecs[i].aa, vecs[i].ad);
      @(negedge clk);
      check($sformatf("v%0d_spi_ready", i), 32'(bus_if.spi_ready), 32'(vecs[i].srdy));
      check($sformatf("v%0d_auto_ready", i), 32'(bus_if.auto_ready), 32'(vecs[i].ardy));
      tick();
      check($sformatf("v%0d_ctrl", i), 32'(reg_control), 32'(vecs[i].ctrl));
      check($sformatf("v%0d_freq", i), 32'({reg_freq_high, reg_freq_mid, reg_freq_low}), 32'(vecs[i].freq));
      check($sformatf("v%0d_duty", i), 32'(reg_duty), 32'(vecs[i].duty));
      check($sformatf("v%0d_vol", i), 32'(reg_volume), 32'(vecs[i].vol));
      check($sformatf("v%0d_commit", i), 32'(freq_commit), 32'(vecs[i].commit));
      check($sformatf("v%0d_err", i), 32'(addr_err), 32'(vecs[i].err));
      check($sformatf("v%0d_status", i), 32'(reg_status), 32'h03);
    end

    status_gate_active = 1'b0;
    #1;
    check("status_comb", 32'(reg_status), 32'h02);
    status_gate_active = 1'b1;

    // Both requesters valid every cycle.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'h05, 8'(i), 1'b1, 8'h06, 8'(8'h80 + i));
`ifdef SYNTH_REG_ARB_RR_EN
      exp_auto = (i % 2) == 1;
`else
      exp_auto = (i % (STARVE_MAX + 1)) == STARVE_MAX;
`endif
      @(negedge clk);
      check($sformatf("arb%0d_spi_ready", i), 32'(bus_if.spi_ready), 32'(!exp_auto));
      check($sformatf("arb%0d_auto_ready", i), 32'(bus_if.auto_ready), 32'(exp_auto));
      tick();
    end

    // Reset while AUTO holds the lock with non-zero shadows.
    do_reset();
    drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h02, 8'h12);
    @(negedge clk);
    check("rm_lock_auto_ready", 32'(bus_if.auto_ready), 32'd1);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h03, 8'h34);
    tick();
    rst = 1'b1;
    drive(1'b1, 8'h05, 8'h66, 1'b1, 8'h04, 8'h99);
    @(negedge clk);
    check("rm_rst_spi_ready", 32'(bus_if.spi_ready), 32'd0);
    check("rm_rst_auto_ready", 32'(bus_if.auto_ready), 32'd0);
    tick();
    rst = 1'b0;
    check("rm_freq", 32'({reg_freq_high, reg_freq_mid, reg_freq_low}), 32'h0);
    check("rm_commit", 32'(freq_commit), 32'd0);
    check("rm_duty", 32'(reg_duty), 32'd0);
    drive(1'b1, 8'h04, 8'h55, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("rm_idle_spi_ready", 32'(bus_if.spi_ready), 32'd1);
    tick();
    check("rm_shadows_clear_freq", 32'({reg_freq_high, reg_freq_mid, reg_freq_low}), 32'h550000);
    check("rm_after_commit", 32'(freq_commit), 32'd1);

    // SPI takes the lock and goes quiet; AUTO's 0x04 must wait for the timeout.
    do_reset();
    drive(1'b1, 8'h02, 8'h5A, 1'b0, 8'h00, 8'h00);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h04, 8'h77);
    found = 0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (bus_if.auto_ready) begin
        found = n;
        break;
      end
      tick();
    end
    check("to_release_cycle", 32'(found), 32'(LOCK_TIMEOUT + 1));
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    check("to_freq", 32'({reg_freq_high, reg_freq_mid, reg_freq_low}), 32'h77005A);
    check("to_commit", 32'(freq_commit), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
